// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache: bus widths, default geometry, FSM encoding.
// Latency: n/a (package).
// Backpressure: n/a (package).
package icache_pkg;

    localparam int INST_ADDR_BUS = 32;
    localparam int INST_BUS      = 32;

    localparam int ICACHE_LINES  = 64;
    localparam int ICACHE_IDX_W  = 6;
    localparam int ICACHE_ADDR_W = 18;

    // pc[17:16] == 2'b11 selects the I/O window, which must never be cached.
    localparam logic [1:0] ICACHE_IO_SEL = 2'b11;

    typedef enum logic {
        ICACHE_IDLE = 1'b0,
        ICACHE_MISS = 1'b1
    } icache_state_e;

endpackage

// File: rtl/icache_array.sv
// Tag/valid/data storage for the direct-mapped icache, one word per line.
// Latency: combinational read; write takes effect at the next clk edge.
// Backpressure: none; the controller gates wr_en (rdy, flush, I/O region).
// Ports: clk, rst (async clears valid bits only), rd_idx -> rd_vld/rd_tag/rd_dat,
//        wr_en/wr_idx/wr_tag/wr_dat single write port.
module icache_array
    import icache_pkg::*;
#(
    parameter int LINES = ICACHE_LINES,
    parameter int IDX_W = ICACHE_IDX_W,
    parameter int TAG_W = ICACHE_ADDR_W - ICACHE_IDX_W - 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_W-1:0]    rd_idx,
    output logic                rd_vld,
    output logic [TAG_W-1:0]    rd_tag,
    output logic [INST_BUS-1:0] rd_dat,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [TAG_W-1:0]    wr_tag,
    input  logic [INST_BUS-1:0] wr_dat
);

    logic [LINES-1:0]    vld_q;
    logic [TAG_W-1:0]    tag_q [LINES];
    logic [INST_BUS-1:0] dat_q [LINES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
        end else if (wr_en) begin
            vld_q[wr_idx] <= 1'b1;
        end
    end

    // Tag/data need no reset: a line is only ever read through its valid bit.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx] <= wr_tag;
            dat_q[wr_idx] <= wr_dat;
        end
    end

    assign rd_vld = vld_q[rd_idx];
    assign rd_tag = tag_q[rd_idx];
    assign rd_dat = dat_q[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache between fetch and mem_control.
// Latency: hit returns 1 cycle after the request; miss returns 1 cycle after mc_done.
// Backpressure: req_ready drops while a refill is outstanding; rdy=0 freezes everything.
// Ports: clk, rst, rdy, branch_interception; fetch side req_valid/req_pc/req_ready,
//        inst_valid/inst_out/inst_pc; refill side mc_req/mc_addr, mc_done/mc_inst.
module icache
    import icache_pkg::*;
#(
    parameter int LINES  = ICACHE_LINES,
    parameter int IDX_W  = ICACHE_IDX_W,
    parameter int ADDR_W = ICACHE_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     branch_interception,
    input  logic                     req_valid,
    input  logic [INST_ADDR_BUS-1:0] req_pc,
    output logic                     req_ready,
    output logic                     inst_valid,
    output logic [INST_BUS-1:0]      inst_out,
    output logic [INST_ADDR_BUS-1:0] inst_pc,
    output logic                     mc_req,
    output logic [INST_ADDR_BUS-1:0] mc_addr,
    input  logic                     mc_done,
    input  logic [INST_BUS-1:0]      mc_inst
);

    localparam int TAG_W = ADDR_W - IDX_W - 2;

    icache_state_e             state_q;
    logic [INST_ADDR_BUS-1:0]  pc_q;
    logic [INST_ADDR_BUS-1:0]  pc_aligned;
    logic                      rd_vld;
    logic [TAG_W-1:0]          rd_tag;
    logic [INST_BUS-1:0]       rd_dat;
    logic                      hit;
    logic                      fill;
    logic                      wr_en;

    assign pc_aligned = req_pc & ~32'h3;
    assign req_ready  = (state_q == ICACHE_IDLE);
    assign hit        = rd_vld && (rd_tag == pc_aligned[ADDR_W-1:IDX_W+2]);

    // Refill completes this edge; the I/O window still returns the word but never allocates.
    assign fill  = rdy && !branch_interception && (state_q == ICACHE_MISS) && mc_req && mc_done;
    assign wr_en = fill && (pc_q[17:16] != ICACHE_IO_SEL);

    icache_array #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clk    (clk),
        .rst    (rst),
        .rd_idx (pc_aligned[IDX_W+1:2]),
        .rd_vld (rd_vld),
        .rd_tag (rd_tag),
        .rd_dat (rd_dat),
        .wr_en  (wr_en),
        .wr_idx (pc_q[IDX_W+1:2]),
        .wr_tag (pc_q[ADDR_W-1:IDX_W+2]),
        .wr_dat (mc_inst)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ICACHE_IDLE;
            pc_q       <= '0;
            inst_valid <= 1'b0;
            inst_out   <= '0;
            inst_pc    <= '0;
            mc_req     <= 1'b0;
            mc_addr    <= '0;
        end else if (rdy) begin
            inst_valid <= 1'b0;
            if (branch_interception) begin
                // Flush wins over everything: drop the request and any refill data.
                mc_req  <= 1'b0;
                state_q <= ICACHE_IDLE;
            end else begin
                case (state_q)
                    ICACHE_IDLE: begin
                        if (req_valid) begin
                            if (hit) begin
                                inst_valid <= 1'b1;
                                inst_out   <= rd_dat;
                                inst_pc    <= pc_aligned;
                            end else begin
                                pc_q    <= pc_aligned;
                                mc_req  <= 1'b1;
                                mc_addr <= pc_aligned;
                                state_q <= ICACHE_MISS;
                            end
                        end
                    end
                    ICACHE_MISS: begin
                        if (fill) begin
                            inst_valid <= 1'b1;
                            inst_out   <= mc_inst;
                            inst_pc    <= pc_q;
                            mc_req     <= 1'b0;
                            state_q    <= ICACHE_IDLE;
                        end
                    end
                    default: state_q <= ICACHE_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_icache.sv
module tb_icache;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] dat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        branch_interception = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_pc = '0;
    logic        req_ready;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        mc_req;
    logic [31:0] mc_addr;
    logic        mc_done = 1'b0;
    logic [31:0] mc_inst = '0;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t exp_q[$];
    logic edge_active = 1'b0;

    logic [31:0] b2b_dat [4];

    icache dut (
        .clk                 (clk),
        .rst                 (rst),
        .rdy                 (rdy),
        .branch_interception (branch_interception),
        .req_valid           (req_valid),
        .req_pc              (req_pc),
        .req_ready           (req_ready),
        .inst_valid          (inst_valid),
        .inst_out            (inst_out),
        .inst_pc             (inst_pc),
        .mc_req              (mc_req),
        .mc_addr             (mc_addr),
        .mc_done             (mc_done),
        .mc_inst             (mc_inst)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Outputs only change on an edge where rdy was high and reset was low.
    always @(posedge clk) edge_active = rdy && !rst;

    // Scoreboard monitor: every delivered word must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && inst_valid && edge_active) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_inst: got pc %h data %h expected no delivery", inst_pc, inst_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("inst_pc", inst_pc, e.pc);
                check("inst_out", inst_out, e.dat);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fetch_hit(input logic [31:0] pc, input logic [31:0] dat);
        exp_q.push_back('{pc: pc, dat: dat});
        req_valid = 1'b1;
        req_pc    = pc;
        tick();
        req_valid = 1'b0;
        check("hit_mc_req", {31'b0, mc_req}, 32'd0);
        check("hit_req_ready", {31'b0, req_ready}, 32'd1);
    endtask

    // Issue a request that must miss; returns after mc_addr/mc_req were checked.
    task automatic issue_miss(input logic [31:0] pc);
        req_valid = 1'b1;
        req_pc    = pc;
        tick();
        req_valid = 1'b0;
        check("miss_mc_req", {31'b0, mc_req}, 32'd1);
        check("miss_mc_addr", mc_addr, pc);
        check("miss_req_ready", {31'b0, req_ready}, 32'd0);
    endtask

    task automatic complete_miss(input logic [31:0] pc, input logic [31:0] dat);
        exp_q.push_back('{pc: pc, dat: dat});
        mc_done = 1'b1;
        mc_inst = dat;
        tick();
        mc_done = 1'b0;
        mc_inst = 32'hDEAD_BEEF;
        check("fill_mc_req", {31'b0, mc_req}, 32'd0);
        check("fill_req_ready", {31'b0, req_ready}, 32'd1);
    endtask

    task automatic fetch_miss(input logic [31:0] pc, input logic [31:0] dat, input int delay);
        issue_miss(pc);
        repeat (delay) begin
            tick();
            check("wait_mc_req", {31'b0, mc_req}, 32'd1);
        end
        complete_miss(pc, dat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        b2b_dat[0] = 32'h00A0_0093;
        b2b_dat[1] = 32'h0010_0113;
        b2b_dat[2] = 32'h0020_81B3;
        b2b_dat[3] = 32'hFE41_9EE3;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_mc_req", {31'b0, mc_req}, 32'd0);
        check("rst_inst_out", inst_out, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        check("rst_mc_addr", mc_addr, 32'd0);
        rst = 1'b0;
        tick();

        // Cold miss then hit.
        fetch_miss(32'h0000_0010, 32'h00A0_0093, 5);
        fetch_hit(32'h0000_0010, 32'h00A0_0093);

        // Fill 0x14..0x1C, then four back-to-back hits.
        for (int i = 1; i < 4; i++) fetch_miss(32'h10 + 4 * i, b2b_dat[i], 1);
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{pc: 32'h10 + 4 * i, dat: b2b_dat[i]});
            req_pc = 32'h10 + 4 * i;
            tick();
            check("b2b_mc_req", {31'b0, mc_req}, 32'd0);
            check("b2b_req_ready", {31'b0, req_ready}, 32'd1);
        end
        req_valid = 1'b0;
        tick();
        check("b2b_pulse_clears", {31'b0, inst_valid}, 32'd0);

        // Conflict on index 4: 0x110 evicts 0x10, which must miss afterwards.
        fetch_miss(32'h0000_0110, 32'h1234_5678, 2);
        fetch_hit(32'h0000_0110, 32'h1234_5678);
        fetch_miss(32'h0000_0010, 32'h00A0_0093, 1);

        // Flush coincident with mc_done: nothing delivered, nothing filled.
        issue_miss(32'h0000_0040);
        tick();
        mc_done = 1'b1;
        mc_inst = 32'h5555_AAAA;
        branch_interception = 1'b1;
        tick();
        mc_done = 1'b0;
        branch_interception = 1'b0;
        check("flush_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("flush_mc_req", {31'b0, mc_req}, 32'd0);
        check("flush_req_ready", {31'b0, req_ready}, 32'd1);
        // Stray mc_done in IDLE is ignored.
        mc_done = 1'b1;
        tick();
        mc_done = 1'b0;
        check("stray_done_inst_valid", {31'b0, inst_valid}, 32'd0);
        fetch_miss(32'h0000_0040, 32'h0000_0040, 1);

        // Flush drops a simultaneous request to a resident line.
        req_valid = 1'b1;
        req_pc = 32'h0000_0014;
        branch_interception = 1'b1;
        tick();
        req_valid = 1'b0;
        branch_interception = 1'b0;
        check("flush_req_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("flush_req_mc_req", {31'b0, mc_req}, 32'd0);
        fetch_hit(32'h0000_0014, b2b_dat[1]);

        // rdy low during a hit response: outputs hold.
        fetch_hit(32'h0000_0018, b2b_dat[2]);
        rdy = 1'b0;
        tick();
        tick();
        check("rdy_hold_valid", {31'b0, inst_valid}, 32'd1);
        check("rdy_hold_out", inst_out, b2b_dat[2]);
        check("rdy_hold_pc", inst_pc, 32'h0000_0018);
        rdy = 1'b1;
        tick();
        check("rdy_release_valid", {31'b0, inst_valid}, 32'd0);

        // rdy low during MISS with mc_done: ignored, no fill.
        issue_miss(32'h0000_0080);
        rdy = 1'b0;
        mc_done = 1'b1;
        mc_inst = 32'hCAFE_F00D;
        tick();
        mc_done = 1'b0;
        rdy = 1'b1;
        tick();
        check("rdy_miss_mc_req", {31'b0, mc_req}, 32'd1);
        check("rdy_miss_inst_valid", {31'b0, inst_valid}, 32'd0);
        branch_interception = 1'b1;
        tick();
        branch_interception = 1'b0;
        fetch_miss(32'h0000_0080, 32'h0000_0813, 1);
        fetch_hit(32'h0000_0080, 32'h0000_0813);

        // I/O window: returned but never allocated.
        fetch_miss(32'h0003_0004, 32'h0BAD_0001, 1);
        fetch_miss(32'h0003_0004, 32'h0BAD_0002, 1);

        // Async reset between edges while a miss is outstanding.
        issue_miss(32'h0000_0200);
        #2 rst = 1'b1;
        #1;
        check("arst_mc_req", {31'b0, mc_req}, 32'd0);
        check("arst_req_ready", {31'b0, req_ready}, 32'd1);
        check("arst_mc_addr", mc_addr, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        fetch_miss(32'h0000_0010, 32'h00A0_0093, 1);
        fetch_miss(32'h0000_0080, 32'h0000_0813, 1);
        fetch_miss(32'h0000_0200, 32'h0000_0200, 1);

        tick();
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, read-only instruction cache between the fetch stage (iF) and mem_control.
- Serves aligned 32-bit instruction fetches. Hits return in 1 cycle. Misses issue a single-word refill request to mem_control, fill the line, then return the word.
- Aborts an outstanding miss when the EX stage raises branch_interception. After reset it cuts the repeated byte-serial fetch latency for loop bodies.

Parameters:
- LINES, 64, number of one-word lines; power of two, 2..256
- IDX_W, 6, log2(LINES); index = pc[IDX_W+1:2]
- ADDR_W, 18, significant address bits; tag = pc[ADDR_W-1:IDX_W+2]

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active high
- rdy  in  1  global ready; when low all state and outputs freeze
- branch_interception  in  1  flush request from EX
- req_valid  in  1  iF presents a fetch this cycle
- req_pc  in  32  fetch address; bits [1:0] ignored
- req_ready  out  1  cache can accept a request (state IDLE)
- inst_valid  out  1  inst_out/inst_pc valid this cycle (1-cycle pulse)
- inst_out  out  32  instruction word
- inst_pc  out  32  address the word belongs to
- mc_req  out  1  refill request to mem_control, held until mc_done
- mc_addr  out  32  word-aligned refill address
- mc_done  in  1  mem_control has the full word (1-cycle pulse)
- mc_inst  in  32  refill data, valid with mc_done

Behaviour:
- Reset (async, rst=1):
  - all valid bits 0; state IDLE
  - req_ready=1, inst_valid=0, mc_req=0
  - inst_out=0, inst_pc=0, mc_addr=0
- Reset mid-refill discards the refill; no line is written.
- rdy=0: no register, array or state update. Outputs hold their values. A pending mc_done in that cycle is ignored; mem_control also stalls on rdy.
- States are IDLE and MISS. The request address is held in an internal pc_q.
- IDLE, req_valid=1, no flush: tag/valid lookup from the register arrays (combinational).
  - Hit: next edge drives inst_valid=1, inst_out=data[idx], inst_pc={req_pc[31:2],2'b00}. State stays IDLE (back-to-back hits, one per cycle).
  - Miss: next edge captures pc_q, sets mc_req=1, mc_addr={req_pc[31:2],2'b00}, goes to MISS, req_ready=0.
- MISS, mc_done=1, no flush, same edge:
  - write data[idx(pc_q)]=mc_inst, tag, valid=1
  - drive inst_valid=1, inst_out=mc_inst, inst_pc=pc_q
  - mc_req=0; return to IDLE
- mc_done with mc_req=0 (stray or late after flush) is ignored.
- inst_valid is a pulse; it clears on the next active edge unless another hit is delivered.
- branch_interception=1, checked before every other event:
  - inst_valid=0 next cycle, mc_req=0, state IDLE
  - any req_valid in that cycle is dropped
  - a simultaneous mc_done is discarded (no fill)
  - the valid array is NOT cleared
- I/O region: if req_pc[17:16]==2'b11 the access is never filled. The miss path runs, and mc_done returns the word without writing the array.
- Index/tag wrap: addresses differing only above ADDR_W alias. This is accepted because memory is 128 KB.
- Conflict: same index, different tag → miss, and the refill overwrites the line.
- req_valid while req_ready=0 is ignored; iF must hold the request until it sees inst_valid for that pc.

Decomposition:
- Shared defines package:
  - InstAddrBus/InstBus widths (existing)
  - new ICacheLines, ICacheIdxW
  - state encodings ICACHE_IDLE / ICACHE_MISS
- One natural sub-module, icache_array: tag/valid/data storage, 1 write port, combinational read, async clear of valid bits. The controller FSM stays in icache.

Test Plan:
- Cold miss: after rst, req pc=0x0000_0010, mc_done with mc_inst=0x00A00093 after 5 cycles → mc_addr=0x10 while mc_req=1. One cycle after mc_done: inst_valid=1, inst_out=0x00A00093, inst_pc=0x10.
- Hit: repeat pc=0x10 → inst_valid=1 one cycle later with same data, mc_req stays 0.
- Back-to-back hits: 4 consecutive requests to 0x10..0x1C (all resident) → 4 consecutive inst_valid pulses, no stall.
- Conflict: fill 0x0000_0010, then request 0x0000_0110 (LINES=64, same index) → miss and refill; a later request to 0x10 misses again.
- Flush during MISS: pc=0x40 misses, branch_interception asserted in the same cycle as mc_done → no inst_valid, state IDLE, and a later request to 0x40 misses.
- rdy low: drop rdy during a hit response and during MISS with mc_done pulsed → outputs held and no fill occurs. Behaviour continues correctly once rdy returns high.
- Async reset mid-MISS: rst asserted between clock edges → mc_req=0 immediately, and all prior lines miss afterwards.
